// File: rtl/slot_ctrl_if.sv
// Bundle between the slot game controller and its surroundings (button, reel, display).
// master = the controller side, slave = the reel/button/display side.
interface slot_ctrl_if;
    logic       start;
    logic [3:0] reel;
    logic       running;
    logic [3:0] result;
    logic       result_valid;
    logic       win;
    logic       pair;
    logic [7:0] credits;
    logic       broke;

    modport master (
        input  start, reel,
        output running, result, result_valid, win, pair, credits, broke
    );

    modport slave (
        output start, reel,
        input  running, result, result_valid, win, pair, credits, broke
    );
endinterface

// File: rtl/slot_ctrl.sv
// Slot machine game controller: debounces a spin request into a timed reel enable,
// captures the settled reel value, scores it and keeps the credit balance.
module slot_ctrl #(
    parameter int unsigned SPIN_CYCLES  = 8,
    parameter logic [3:0]  LUCKY        = 4'd7,
    parameter logic [7:0]  PAYOUT       = 8'd5,
    parameter logic [7:0]  INIT_CREDITS = 8'd10
) (
    input  logic         clk,
    input  logic         rst,
    slot_ctrl_if.master  bus
);
    localparam int CNT_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SPIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SPIN, SETTLE, JUDGE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic [3:0]       result_q, result_d;
    logic             valid_q, valid_d;
    logic             win_q, win_d;
    logic             pair_q, pair_d;
    logic [7:0]       credits_q, credits_d;
    logic             prev_valid_q, prev_valid_d;
    logic             start_edge;
    logic             spin_go;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Two synchroniser stages plus one history flop for the rising-edge detector.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 3'b000;
        else     sync_q <= {sync_q[1:0], bus.start};
    end

    assign start_edge = sync_q[1] & ~sync_q[2];
    assign spin_go    = (state_q == IDLE) && start_edge && (credits_q != 8'd0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (spin_go) state_d = SPIN;
            SPIN:    if (cnt_q == '0) state_d = SETTLE;
            SETTLE:  state_d = JUDGE;
            JUDGE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        running_d    = running_q;
        result_d     = result_q;
        valid_d      = 1'b0;
        win_d        = win_q;
        pair_d       = pair_q;
        credits_d    = credits_q;
        prev_valid_d = prev_valid_q;
        case (state_q)
            IDLE: begin
                if (spin_go) begin
                    running_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                    credits_d = credits_q - 8'd1;
                    win_d     = 1'b0;
                    pair_d    = 1'b0;
                end
            end
            SPIN: begin
                if (cnt_q == '0) running_d = 1'b0;
                else             cnt_d     = cnt_q - 1'b1;
            end
            JUDGE: begin
                result_d     = bus.reel;
                valid_d      = 1'b1;
                prev_valid_d = 1'b1;
                // Jackpot wins over a repeat of the previous value.
                if (bus.reel == LUCKY) begin
                    win_d     = 1'b1;
                    credits_d = sat_add(credits_q, PAYOUT);
                end else if (prev_valid_q && (bus.reel == result_q)) begin
                    pair_d    = 1'b1;
                    credits_d = sat_add(credits_q, 8'd1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            running_q    <= 1'b0;
            result_q     <= 4'd0;
            valid_q      <= 1'b0;
            win_q        <= 1'b0;
            pair_q       <= 1'b0;
            credits_q    <= INIT_CREDITS;
            prev_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            running_q    <= running_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            win_q        <= win_d;
            pair_q       <= pair_d;
            credits_q    <= credits_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign bus.running      = running_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.win          = win_q;
    assign bus.pair         = pair_q;
    assign bus.credits      = credits_q;
    assign bus.broke        = (credits_q == 8'd0);
endmodule
